// File: rtl/lsu_pkg.sv
// lsu_pkg: memory opcodes, RV32 funct3 load/store codes and FSM states for lsu_req_ctrl
package lsu_pkg;
    localparam logic [2:0] LB   = 3'd0;
    localparam logic [2:0] LHW  = 3'd1;
    localparam logic [2:0] LW   = 3'd2;
    localparam logic [2:0] SB   = 3'd3;
    localparam logic [2:0] SHW  = 3'd4;
    localparam logic [2:0] SW   = 3'd5;
    localparam logic [2:0] LBU  = 3'd6;
    localparam logic [2:0] LHWU = 3'd7;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/lsu_req_fmt.sv
// lsu_req_fmt: decodes funct3/store into memory opcode, legality, misalignment and aligned low address bits
//   store, funct3, ea_lo  : decoded instruction kind and low two bits of the effective address
//   opcode, legal         : memory opcode and whether funct3 names a real load/store
//   misal                 : misaligned halfword/word (only when LSU_MISALIGN_EXC_EN is defined, else 0)
//   addr_lo               : ea_lo with the sub-access bits cleared (aligned down)
module lsu_req_fmt
    import lsu_pkg::*;
(
    input  logic       store,
    input  logic [2:0] funct3,
    input  logic [1:0] ea_lo,
    output logic [2:0] opcode,
    output logic       legal,
    output logic       misal,
    output logic [1:0] addr_lo
);
    logic half, word;
    logic [1:0] lo_mask;
    always_comb begin
        half    = funct3 == F3_H || funct3 == F3_HU;
        word    = funct3 == F3_W;
        legal   = funct3 == F3_B || funct3 == F3_H || funct3 == F3_W
                  || (!store && (funct3 == F3_BU || funct3 == F3_HU));
        opcode  = store ? (half ? SHW : word ? SW : SB)
                        : (funct3 == F3_BU ? LBU : funct3 == F3_HU ? LHWU : half ? LHW : word ? LW : LB);
        lo_mask = {word, half | word};
        addr_lo = ea_lo & ~lo_mask;
`ifdef LSU_MISALIGN_EXC_EN
        misal   = legal && |(ea_lo & lo_mask);
`else
        misal   = 1'b0;
`endif
    end
endmodule

// File: rtl/lsu_req_ctrl.sv
// lsu_req_ctrl: RV32 load/store initiator holding a memory request for a fixed latency
//   CLK/RSTn                       : clock, async active-low reset
//   req_valid/ready/store/funct3/base/imm/wdata/rd : EX-stage request handshake
//   mem_stall/opcode/addr/wdata/rdata              : byte-lane memory port (mem_stall=0 while active)
//   wb_valid/rd/data               : load writeback pulse
//   done, pipe_stall, misalign     : retire pulse, pipeline stall, misaligned-access pulse
//   Macro LSU_MISALIGN_EXC_EN: misaligned H/W accesses fault instead of being aligned down.
module lsu_req_ctrl
    import lsu_pkg::*;
#(
    parameter int RD_LAT = 3,
    parameter int ST_LAT = 2,
    parameter int AW     = 12
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_store,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_base,
    input  logic [11:0]   req_imm,
    input  logic [31:0]   req_wdata,
    input  logic [4:0]    req_rd,
    output logic          mem_stall,
    output logic [2:0]    mem_opcode,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          wb_valid,
    output logic [4:0]    wb_rd,
    output logic [31:0]   wb_data,
    output logic          done,
    output logic          pipe_stall,
    output logic          misalign
);
    state_t state, state_n;
    logic [7:0] cnt;
    logic is_ld, flt, mis;
    logic [2:0] f_opc;
    logic f_legal, f_mis;
    logic [1:0] f_lo;
    logic [31:0] sum;
    logic [AW-1:0] ea;
    logic fault_in, unused_sum;

    assign sum        = req_base + {{20{req_imm[11]}}, req_imm};
    assign ea         = sum[AW-1:0];
    assign unused_sum = ^sum;
    assign fault_in   = ~f_legal | f_mis;

    lsu_req_fmt u_fmt (
        .store   (req_store),
        .funct3  (req_funct3),
        .ea_lo   (ea[1:0]),
        .opcode  (f_opc),
        .legal   (f_legal),
        .misal   (f_mis),
        .addr_lo (f_lo)
    );

    // Faulted requests skip ISSUE so the bus never leaves the idle state.
    always_comb begin
        state_n = state == IDLE  ? (req_valid ? (fault_in ? RESP : ISSUE) : IDLE)
                : state == ISSUE ? (cnt == 8'd0 ? RESP : ISSUE)
                : IDLE;
    end

    assign req_ready  = state == IDLE;
    assign pipe_stall = ~req_ready;
    assign mem_stall  = state != ISSUE;
    assign done       = state == RESP;
    assign wb_valid   = done & is_ld & ~flt;
    assign misalign   = done & mis;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_opcode <= LW;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wb_rd      <= '0;
            wb_data    <= '0;
            is_ld      <= 1'b0;
            flt        <= 1'b0;
            mis        <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && req_valid) begin
                cnt        <= req_store ? 8'(ST_LAT - 1) : 8'(RD_LAT - 1);
                mem_opcode <= f_opc;
                mem_addr   <= {ea[AW-1:2], f_lo};
                mem_wdata  <= req_wdata;
                wb_rd      <= req_rd;
                is_ld      <= ~req_store;
                flt        <= fault_in;
                mis        <= f_mis;
            end else if (state == ISSUE) begin
                cnt <= cnt - 8'd1;
                // Last ISSUE cycle is when the memory presents load data.
                if (cnt == 8'd0 && is_ld)
                    wb_data <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_lsu_req_ctrl.sv
// tb_lsu_req_ctrl: scoreboard bench for lsu_req_ctrl with a latency-accurate memory model
module tb_lsu_req_ctrl;
    import lsu_pkg::*;
    localparam int RD_LAT = 3;
    localparam int ST_LAT = 2;

    logic        CLK = 0, RSTn = 0;
    logic        req_valid = 0, req_store = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_base = 0, req_wdata = 0;
    logic [11:0] req_imm = 0;
    logic [4:0]  req_rd = 0;
    logic        req_ready, mem_stall, wb_valid, done, pipe_stall, misalign;
    logic [2:0]  mem_opcode;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata, wb_data;
    logic [4:0]  wb_rd;

    int errors = 0, checks = 0;

    typedef struct {
        logic        st;
        logic [2:0]  opc;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] data;
        int          issue;
        logic        wbv;
        logic        mis;
    } exp_t;
    exp_t sb[$];

    int          obs_wait, obs_issue, obs_lat, obs_wbn;
    logic        obs_stable, obs_ps_ok, obs_wbv, obs_mis;
    logic [2:0]  obs_opc;
    logic [11:0] obs_addr;
    logic [31:0] obs_wd, obs_data;
    logic [4:0]  obs_rd;

    lsu_req_ctrl #(.RD_LAT(RD_LAT), .ST_LAT(ST_LAT), .AW(12)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_imm(req_imm),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_stall(mem_stall), .mem_opcode(mem_opcode), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(done), .pipe_stall(pipe_stall), .misalign(misalign)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_fn(input logic [11:0] a, input logic [2:0] op);
        return a == 12'h104 ? 32'hDEADBEEF : {8'h5A, 1'b0, op, 8'h00, a};
    endfunction

    // Memory returns valid data only on the RD_LAT-th consecutive active cycle.
    int icnt;
    always @(posedge CLK or negedge RSTn) icnt <= (!RSTn || mem_stall) ? 0 : icnt + 1;
    assign mem_rdata = (!mem_stall && icnt == RD_LAT - 1) ? mem_fn(mem_addr, mem_opcode) : 32'hBAD0BAD0;

    function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] base,
                                   input logic [11:0] imm, input logic [31:0] wd, input logic [4:0] rd);
        exp_t e;
        logic [31:0] s;
        logic [11:0] ea;
        logic lg, h, w, m, ft;
        s  = base + {{20{imm[11]}}, imm};
        ea = s[11:0];
        h  = f3 == 3'b001 || f3 == 3'b101;
        w  = f3 == 3'b010;
        lg = st ? (f3 <= 3'b010) : (f3 <= 3'b010 || f3 == 3'b100 || f3 == 3'b101);
        m  = lg && ((h && ea[0]) || (w && ea[1:0] != 2'b00));
        e.opc = st ? (f3 == 3'b000 ? SB : f3 == 3'b001 ? SHW : SW)
                   : (f3 == 3'b000 ? LB : f3 == 3'b001 ? LHW : f3 == 3'b010 ? LW : f3 == 3'b100 ? LBU : LHWU);
`ifdef LSU_MISALIGN_EXC_EN
        ft = !lg || m;
        e.mis = m;
        e.addr = ea;
`else
        ft = !lg;
        e.mis = 1'b0;
        e.addr = w ? {ea[11:2], 2'b00} : h ? {ea[11:1], 1'b0} : ea;
`endif
        e.issue = ft ? 0 : st ? ST_LAT : RD_LAT;
        e.wbv   = !st && !ft;
        e.st = st; e.wd = wd; e.rd = rd;
        e.data  = mem_fn(e.addr, e.opc);
        return e;
    endfunction

    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                           input logic [11:0] imm, input logic [31:0] wd, input logic [4:0] rd, input bit hold);
        @(negedge CLK);
        req_valid = 1; req_store = st; req_funct3 = f3; req_base = base;
        req_imm = imm; req_wdata = wd; req_rd = rd;
        obs_wait = 0;
        while (!req_ready && obs_wait < 20) begin
            @(negedge CLK);
            obs_wait++;
        end
        sb.push_back(model(st, f3, base, imm, wd, rd));
        @(posedge CLK); #1;
        if (!hold) req_valid = 0;
        obs_issue = 0; obs_lat = 0; obs_wbn = 0; obs_stable = 1; obs_ps_ok = 1;
        obs_wbv = 0; obs_mis = 0; obs_rd = 0; obs_data = 0; obs_opc = 0; obs_addr = 0; obs_wd = 0;
        for (int c = 1; c <= 20 && obs_lat == 0; c++) begin
            @(negedge CLK);
            if (!pipe_stall || req_ready) obs_ps_ok = 0;
            obs_wbn += int'(wb_valid);
            if (!mem_stall) begin
                if (obs_issue == 0) begin
                    obs_opc = mem_opcode; obs_addr = mem_addr; obs_wd = mem_wdata;
                end else if (mem_opcode !== obs_opc || mem_addr !== obs_addr || mem_wdata !== obs_wd)
                    obs_stable = 0;
                obs_issue++;
            end
            if (done) begin
                obs_lat = c; obs_wbv = wb_valid; obs_rd = wb_rd; obs_data = wb_data; obs_mis = misalign;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge CLK);
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL rst mem_stall got=%b exp=1", mem_stall); end
        checks++; if (mem_opcode !== LW) begin errors++; $display("FAIL rst mem_opcode got=%0d exp=%0d", mem_opcode, LW); end
        checks++; if (mem_addr !== 12'h0) begin errors++; $display("FAIL rst mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst wb_valid got=%b exp=0", wb_valid); end
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL rst wb_rd got=%0d exp=0", wb_rd); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL rst wb_data got=%h exp=0", wb_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst done got=%b exp=0", done); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst misalign got=%b exp=0", misalign); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst req_ready got=%b exp=1", req_ready); end
        checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL rst pipe_stall got=%b exp=0", pipe_stall); end
        RSTn = 1;
    endtask

    task automatic test_loads;
        logic [2:0]  f3s[5]   = '{3'b010, 3'b100, 3'b000, 3'b101, 3'b010};
        logic [31:0] bases[5] = '{32'h100, 32'hFFF, 32'h0, 32'h200, 32'h104};
        logic [11:0] imms[5]  = '{12'd4, 12'd2, 12'hFFF, 12'hFFE, 12'd0};
        logic [4:0]  rds[5]   = '{5'd7, 5'd3, 5'd9, 5'd31, 5'd0};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, f3s[i], bases[i], imms[i], 32'h0, rds[i], 1'b0);
            e = sb.pop_front();
            checks++; if (obs_lat !== e.issue + 1) begin errors++; $display("FAIL load[%0d] lat got=%0d exp=%0d", i, obs_lat, e.issue + 1); end
            checks++; if (obs_issue !== e.issue) begin errors++; $display("FAIL load[%0d] issue_cycles got=%0d exp=%0d", i, obs_issue, e.issue); end
            checks++; if (obs_addr !== e.addr) begin errors++; $display("FAIL load[%0d] addr got=%h exp=%h", i, obs_addr, e.addr); end
            checks++; if (obs_opc !== e.opc) begin errors++; $display("FAIL load[%0d] opcode got=%0d exp=%0d", i, obs_opc, e.opc); end
            checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL load[%0d] bus_hold got=%b exp=1", i, obs_stable); end
            checks++; if (obs_wbv !== 1'b1 || obs_wbn !== 1) begin errors++; $display("FAIL load[%0d] wb_valid got=%b/%0d exp=1/1", i, obs_wbv, obs_wbn); end
            checks++; if (obs_rd !== e.rd) begin errors++; $display("FAIL load[%0d] wb_rd got=%0d exp=%0d", i, obs_rd, e.rd); end
            checks++; if (obs_data !== e.data) begin errors++; $display("FAIL load[%0d] wb_data got=%h exp=%h", i, obs_data, e.data); end
            checks++; if (obs_ps_ok !== 1'b1) begin errors++; $display("FAIL load[%0d] pipe_stall got=0 exp=1", i); end
        end
    endtask

    task automatic test_stores;
        logic [2:0]  f3s[3]   = '{3'b000, 3'b001, 3'b010};
        logic [31:0] bases[3] = '{32'h7FF, 32'h10, 32'hABC};
        logic [11:0] imms[3]  = '{12'd1, 12'd2, 12'd4};
        logic [31:0] wds[3]   = '{32'hA5, 32'h1234BEEF, 32'hCAFEF00D};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            run_req(1'b1, f3s[i], bases[i], imms[i], wds[i], 5'd1, 1'b0);
            e = sb.pop_front();
            checks++; if (obs_lat !== e.issue + 1) begin errors++; $display("FAIL store[%0d] lat got=%0d exp=%0d", i, obs_lat, e.issue + 1); end
            checks++; if (obs_issue !== e.issue) begin errors++; $display("FAIL store[%0d] issue_cycles got=%0d exp=%0d", i, obs_issue, e.issue); end
            checks++; if (obs_addr !== e.addr) begin errors++; $display("FAIL store[%0d] addr got=%h exp=%h", i, obs_addr, e.addr); end
            checks++; if (obs_opc !== e.opc) begin errors++; $display("FAIL store[%0d] opcode got=%0d exp=%0d", i, obs_opc, e.opc); end
            checks++; if (obs_wd !== e.wd) begin errors++; $display("FAIL store[%0d] wdata got=%h exp=%h", i, obs_wd, e.wd); end
            checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL store[%0d] bus_hold got=%b exp=1", i, obs_stable); end
            checks++; if (obs_wbn !== 0) begin errors++; $display("FAIL store[%0d] wb_valid pulses got=%0d exp=0", i, obs_wbn); end
        end
    endtask

    task automatic test_misalign;
        logic        sts[3]   = '{1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s[3]   = '{3'b001, 3'b010, 3'b010};
        logic [31:0] bases[3] = '{32'h100, 32'h100, 32'h103};
        logic [11:0] imms[3]  = '{12'd1, 12'd2, 12'd0};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            run_req(sts[i], f3s[i], bases[i], imms[i], 32'h55AA55AA, 5'd12, 1'b0);
            e = sb.pop_front();
            checks++; if (obs_lat !== e.issue + 1) begin errors++; $display("FAIL mis[%0d] lat got=%0d exp=%0d", i, obs_lat, e.issue + 1); end
            checks++; if (obs_issue !== e.issue) begin errors++; $display("FAIL mis[%0d] issue_cycles got=%0d exp=%0d", i, obs_issue, e.issue); end
            checks++; if (obs_mis !== e.mis) begin errors++; $display("FAIL mis[%0d] misalign got=%b exp=%b", i, obs_mis, e.mis); end
            checks++; if (obs_wbn !== int'(e.wbv)) begin errors++; $display("FAIL mis[%0d] wb_valid pulses got=%0d exp=%0d", i, obs_wbn, e.wbv); end
            if (e.issue != 0) begin
                checks++; if (obs_addr !== e.addr) begin errors++; $display("FAIL mis[%0d] addr got=%h exp=%h", i, obs_addr, e.addr); end
                checks++; if (obs_opc !== e.opc) begin errors++; $display("FAIL mis[%0d] opcode got=%0d exp=%0d", i, obs_opc, e.opc); end
            end
        end
    endtask

    task automatic test_illegal;
        logic       sts[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0] f3s[5] = '{3'b011, 3'b110, 3'b111, 3'b100, 3'b011};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            run_req(sts[i], f3s[i], 32'h300, 12'd0, 32'h0, 5'd2, 1'b0);
            e = sb.pop_front();
            checks++; if (obs_lat !== e.issue + 1) begin errors++; $display("FAIL ill[%0d] lat got=%0d exp=%0d", i, obs_lat, e.issue + 1); end
            checks++; if (obs_issue !== e.issue) begin errors++; $display("FAIL ill[%0d] issue_cycles got=%0d exp=%0d", i, obs_issue, e.issue); end
            checks++; if (obs_wbn !== 0 || obs_mis !== 1'b0) begin errors++; $display("FAIL ill[%0d] wb/mis got=%0d/%b exp=0/0", i, obs_wbn, obs_mis); end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        run_req(1'b0, 3'b010, 32'h100, 12'd4, 32'h0, 5'd6, 1'b1);
        e = sb.pop_front();
        checks++; if (obs_issue !== e.issue) begin errors++; $display("FAIL b2b first issue_cycles got=%0d exp=%0d", obs_issue, e.issue); end
        checks++; if (obs_lat !== e.issue + 1 || obs_wbn !== 1) begin errors++; $display("FAIL b2b first lat/wb got=%0d/%0d exp=%0d/1", obs_lat, obs_wbn, e.issue + 1); end
        run_req(1'b0, 3'b010, 32'h100, 12'd4, 32'h0, 5'd6, 1'b0);
        e = sb.pop_front();
        checks++; if (obs_wait !== 0) begin errors++; $display("FAIL b2b second wait got=%0d exp=0", obs_wait); end
        checks++; if (obs_lat !== e.issue + 1 || obs_data !== e.data) begin errors++; $display("FAIL b2b second lat/data got=%0d/%h exp=%0d/%h", obs_lat, obs_data, e.issue + 1, e.data); end
    endtask

    task automatic test_reset_mid;
        int nd = 0;
        exp_t e;
        @(negedge CLK);
        req_valid = 1; req_store = 0; req_funct3 = 3'b010; req_base = 32'h100; req_imm = 12'd4; req_rd = 5'd5;
        @(posedge CLK); #1;
        req_valid = 0;
        @(posedge CLK); #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rstmid in_issue mem_stall got=%b exp=0", mem_stall); end
        RSTn = 0; #1;
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL rstmid mem_stall got=%b exp=1", mem_stall); end
        checks++; if (req_ready !== 1'b1 || pipe_stall !== 1'b0) begin errors++; $display("FAIL rstmid ready/stall got=%b/%b exp=1/0", req_ready, pipe_stall); end
        repeat (2) begin @(negedge CLK); nd += int'(done) + int'(wb_valid); end
        RSTn = 1;
        repeat (4) begin @(negedge CLK); nd += int'(done) + int'(wb_valid); end
        checks++; if (nd !== 0) begin errors++; $display("FAIL rstmid stray done/wb got=%0d exp=0", nd); end
        run_req(1'b0, 3'b010, 32'h104, 12'd0, 32'h0, 5'd4, 1'b0);
        e = sb.pop_front();
        checks++; if (obs_lat !== e.issue + 1 || obs_data !== e.data || obs_rd !== e.rd) begin
            errors++; $display("FAIL rstmid after lat/data/rd got=%0d/%h/%0d exp=%0d/%h/%0d", obs_lat, obs_data, obs_rd, e.issue + 1, e.data, e.rd);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misalign();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
